pll_drp_reconfig: RTL
=====================

# pll_drp_reconfig

Dynamic-reconfiguration master for the simulated 7-series PLL: drives the PLL's DRP port (DADDR/DEN/DWE/DI in, DO/DRDY out of the PLL) and its RST input from a stream of masked register updates. It holds the PLL in reset, performs one read-modify-write per entry, then releases reset and waits for LOCKED. It sits between host or testbench logic and a `pll`/PLLE2_ADV instance, and shares that instance's DRP clock.

## Interface
Parameters:
- RST_HOLD, 4: cycles PLL_RST is held high before the first DRP access (1..255).
- DRDY_TIMEOUT, 64: maximum cycles from a DEN pulse to DRDY before abort (2..1023).
- LOCK_TIMEOUT, 65535: maximum cycles from PLL_RST release to LOCKED before abort (1..2^20-1).

Ports:
- DCLK  in  1  clock; also the DRP clock of the PLL.
- RST  in  1  asynchronous, active-high reset of this block.
- CFG_ADDR  in  7  DRP register address of the entry.
- CFG_DATA  in  16  new bit values.
- CFG_MASK  in  16  1 = keep the current bit, 0 = take the CFG_DATA bit.
- CFG_LAST  in  1  marks the final entry of a reconfiguration.
- CFG_VALID  in  1  entry valid.
- CFG_READY  out  1  block accepts an entry.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable; one-cycle pulse.
- DWE  out  1  DRP write enable; qualified by DEN.
- DI  out  16  DRP write data.
- DO  in  16  DRP read data; valid with DRDY.
- DRDY  in  1  DRP access complete.
- PLL_RST  out  1  reset to the PLL.
- LOCKED  in  1  PLL lock indicator.
- BUSY  out  1  reconfiguration in progress.
- DONE  out  1  one-cycle pulse at the end of a sequence, including aborts.
- ERR  out  1  sticky error flag; cleared when the next sequence starts.

## Operation
- States: IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, [VF, VF_WAIT], NEXT, LOCK_WAIT.
- Handshake: an entry transfers when CFG_VALID && CFG_READY, and ADDR/DATA/MASK/LAST are latched on transfer. CFG_READY = 1 only in IDLE and NEXT. It is combinational from state and independent of CFG_VALID.
- IDLE, on transfer: clear ERR, set BUSY and PLL_RST, go to HOLD.
- HOLD: counts RST_HOLD cycles, then goes to RD.
- RD: DEN=1, DWE=0, DADDR=latched address for one cycle, then RD_WAIT.
- RD_WAIT, on DRDY: register merged = (DO & MASK) | (CFG_DATA & ~MASK), then go to WR.
- WR: DEN=1, DWE=1, DI=merged for one cycle, then WR_WAIT.
- WR_WAIT, on DRDY: if LAST go to LOCK_WAIT and drop PLL_RST; otherwise go to NEXT.
- NEXT: PLL_RST stays high indefinitely. On transfer go straight to RD; HOLD is not repeated.
- LOCK_WAIT: when LOCKED is sampled high, go to IDLE, pulse DONE and drop BUSY.
- DRDY timeout: no DRDY within DRDY_TIMEOUT cycles in any *_WAIT state sets ERR, drops PLL_RST, pulses DONE and returns to IDLE. LOCK_TIMEOUT expiry in LOCK_WAIT does the same.
- DRDY outside the *_WAIT states, or in the same cycle as DEN, is ignored.
- When not pulsing, DEN=DWE=0. DADDR and DI hold their last values.
- Controller reset mid-sequence forces all outputs to their reset values, including PLL_RST=0. The PLL then holds a partial configuration, and the host must rerun the sequence.

## Timing
- Reset values: CFG_READY=1 (IDLE); DEN=DWE=0; DADDR=0; DI=0; PLL_RST=0; BUSY=0; DONE=0; ERR=0.
- Accept at cycle t. PLL_RST and BUSY go high at t+1. The first DEN (read) is at t+1+RST_HOLD.
- DRDY in cycle d gives the write DEN at d+1. The next read follows the cycle after the NEXT transfer.
- Last write DRDY at cycle w gives PLL_RST=0 at w+1. LOCKED first sampled high at cycle l gives DONE=1, BUSY=0 at l+1.
- Timeout counters start in the cycle after DEN (or after PLL_RST falls) and fire at count == limit.
- Minimum single-entry sequence with immediate DRDY and LOCKED: RST_HOLD + 6 cycles from accept to DONE.

## Configuration
- PLL_DRP_READBACK_EN defined: after each WR_WAIT, states VF/VF_WAIT issue a read of the same address. If DO != merged, set ERR but continue the sequence. This adds 2+ cycles per entry.
- Not defined: VF/VF_WAIT are absent, and ERR is set only by timeouts.

## Test plan
- Single entry ADDR=0x08, MASK=0x1000, DATA=0x0041, DO=0xF0FF, DRDY one cycle after DEN, LOCKED 10 cycles after PLL_RST falls -> write DI=0x10 41 (0x1041), DONE at RST_HOLD+16 cycles after accept, ERR=0.
- Three entries, the last with CFG_LAST, and CFG_VALID gapped 20 cycles between entries -> PLL_RST stays high throughout, HOLD occurs once, three read/write pairs in order, a single DONE.
- DRDY never returns on the read -> ERR=1, PLL_RST=0 and DONE pulse exactly DRDY_TIMEOUT+1 cycles after the read DEN.
- LOCKED held low -> ERR=1 and DONE after LOCK_TIMEOUT cycles; the next accepted entry clears ERR.
- RST asserted asynchronously in WR_WAIT -> all outputs return to reset values immediately; a fresh sequence afterwards completes normally.
- With PLL_DRP_READBACK_EN defined, a verify read returning 0x0000 instead of 0x1041 -> ERR=1, the sequence still completes and DONE pulses.

Source files
------------

// File: rtl/pll_drp_reconfig.sv
// DRP read-modify-write master for a 7-series PLL: holds PLL reset, applies masked register
// updates, then waits for LOCKED. Defining PLL_DRP_READBACK_EN adds a verify read after each write.
module pll_drp_reconfig #(
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic [6:0]  CFG_ADDR,
  input  logic [15:0] CFG_DATA,
  input  logic [15:0] CFG_MASK,
  input  logic        CFG_LAST,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
    ST_VF,
    ST_VF_WAIT,
`endif
    ST_NEXT,
    ST_LOCK_WAIT
  } state_t;

  localparam logic [19:0] HOLD_LAST = 20'(RST_HOLD - 1);
  localparam logic [19:0] DRDY_LIM  = 20'(DRDY_TIMEOUT);
  localparam logic [19:0] LOCK_LIM  = 20'(LOCK_TIMEOUT);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d, daddr_q, daddr_d;
  logic [15:0] data_q, data_d, mask_q, mask_d, di_q, di_d;
  logic        last_q, last_d;
  logic        pll_rst_q, pll_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        accept, abort, entry_done;

  assign CFG_READY = (state_q == ST_IDLE) || (state_q == ST_NEXT);
  assign accept    = CFG_VALID && CFG_READY;
  assign DADDR     = daddr_q;
  assign DI        = di_q;
  assign PLL_RST   = pll_rst_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      last_q    <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      pll_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      pll_rst_q <= pll_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // The counter is zeroed on entry to every timed state, so count == limit lands
  // exactly 'limit' cycles after the DEN pulse or the PLL_RST release.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 20'd1;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    pll_rst_d  = pll_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    DEN        = 1'b0;
    DWE        = 1'b0;
    abort      = 1'b0;
    entry_done = 1'b0;

    if (accept) begin
      addr_d = CFG_ADDR;
      data_d = CFG_DATA;
      mask_d = CFG_MASK;
      last_d = CFG_LAST;
    end

    case (state_q)
      ST_IDLE: if (accept) begin
        err_d     = 1'b0;
        busy_d    = 1'b1;
        pll_rst_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_HOLD;
      end
      ST_HOLD: if (cnt_q == HOLD_LAST) begin
        daddr_d = addr_q;
        cnt_d   = '0;
        state_d = ST_RD;
      end
      ST_RD: begin
        DEN     = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (DRDY) begin
          di_d    = (DO & mask_q) | (data_q & ~mask_q);
          cnt_d   = '0;
          state_d = ST_WR;
        end else if (cnt_q == DRDY_LIM) begin
          abort = 1'b1;
        end
      end
      ST_WR: begin
        DEN     = 1'b1;
        DWE     = 1'b1;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (DRDY) begin
`ifdef PLL_DRP_READBACK_EN
          cnt_d   = '0;
          state_d = ST_VF;
`else
          entry_done = 1'b1;
`endif
        end else if (cnt_q == DRDY_LIM) begin
          abort = 1'b1;
        end
      end
`ifdef PLL_DRP_READBACK_EN
      ST_VF: begin
        DEN     = 1'b1;
        state_d = ST_VF_WAIT;
      end
      ST_VF_WAIT: begin
        if (DRDY) begin
          if (DO != di_q) err_d = 1'b1;
          entry_done = 1'b1;
        end else if (cnt_q == DRDY_LIM) begin
          abort = 1'b1;
        end
      end
`endif
      ST_NEXT: if (accept) begin
        daddr_d = CFG_ADDR;
        cnt_d   = '0;
        state_d = ST_RD;
      end
      ST_LOCK_WAIT: begin
        if (LOCKED) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == LOCK_LIM) begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (entry_done) begin
      cnt_d = '0;
      if (last_q) begin
        pll_rst_d = 1'b0;
        state_d   = ST_LOCK_WAIT;
      end else begin
        state_d = ST_NEXT;
      end
    end

    if (abort) begin
      err_d     = 1'b1;
      pll_rst_d = 1'b0;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

endmodule
